// File: rtl/logic_unit_arbiter_pkg.sv
// rtl/logic_unit_arbiter_pkg.sv - shared op codes, FSM states and requester ids
// Purpose: common definitions for the shared logic unit arbiter slice.
package logic_unit_arbiter_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/logic_rr_arbiter.sv
// rtl/logic_rr_arbiter.sv - combinational 2-way round-robin pick
// Purpose: choose one of two requesters, favouring the one not granted last.
// Ports:
//   valid0_i, valid1_i  request valids
//   last_grant_i        id of the requester that completed most recently
//   grant_valid_o       some requester is granted
//   grant_id_o          id of the granted requester
module logic_rr_arbiter
    import logic_unit_arbiter_pkg::*;
(
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic last_grant_i,
    output logic grant_valid_o,
    output logic grant_id_o
);

    always_comb begin
        grant_valid_o = valid0_i | valid1_i;
        if (valid0_i && valid1_i) begin
            // Tie: hand the unit to whoever did not have it last.
            grant_id_o = ~last_grant_i;
        end else if (valid1_i) begin
            grant_id_o = REQ1;
        end else begin
            grant_id_o = REQ0;
        end
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - one 32-bit AND/OR/XOR/NOR unit shared by two requesters
// Purpose: round-robin arbitration of a registered logic unit, one transaction in flight.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   rN_valid/rN_ready             request handshake (rN_ready combinational)
//   rN_op, rN_a, rN_b             request op select and operands
//   rN_rvalid/rN_rready           response handshake
//   rN_result                     result register, qualified by rN_rvalid
//   busy                          FSM not in IDLE
//   op_count                      saturating count of completed transactions
module logic_unit_arbiter
    import logic_unit_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [1:0]       r0_op,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    output logic             r0_rvalid,
    input  logic             r0_rready,
    output logic [WIDTH-1:0] r0_result,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [1:0]       r1_op,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    output logic             r1_rvalid,
    input  logic             r1_rready,
    output logic [WIDTH-1:0] r1_result,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               owner_q, owner_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic grant_valid;
    logic grant_id;
    logic owner_rready;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic_rr_arbiter u_rr (
        .valid0_i      (r0_valid),
        .valid1_i      (r1_valid),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= REQ1;
            owner_q      <= REQ0;
            op_q         <= 2'b00;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            result_q     <= result_d;
            count_q      <= count_d;
        end
    end

    assign owner_rready = (owner_q == REQ1) ? r1_rready : r0_rready;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        result_d     = result_q;
        count_d      = count_q;
        case (state_q)
            ST_IDLE: begin
                // Any valid in IDLE is granted and therefore handshaken.
                if (grant_valid) begin
                    owner_d = grant_id;
                    op_d    = (grant_id == REQ1) ? r1_op : r0_op;
                    a_d     = (grant_id == REQ1) ? r1_a  : r0_a;
                    b_d     = (grant_id == REQ1) ? r1_b  : r0_b;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (op_q)
                    OP_AND:  result_d = a_q & b_q;
                    OP_OR:   result_d = a_q | b_q;
                    OP_XOR:  result_d = a_q ^ b_q;
                    OP_NOR:  result_d = ~(a_q | b_q);
                    default: result_d = a_q & b_q;
                endcase
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (owner_rready) begin
                    state_d      = ST_IDLE;
                    last_grant_d = owner_q;
                    if (!(&count_q)) begin
                        count_d = count_q + CNT_ONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign r0_ready  = (state_q == ST_IDLE) && grant_valid && (grant_id == REQ0);
    assign r1_ready  = (state_q == ST_IDLE) && grant_valid && (grant_id == REQ1);
    assign r0_rvalid = (state_q == ST_RESP) && (owner_q == REQ0);
    assign r1_rvalid = (state_q == ST_RESP) && (owner_q == REQ1);
    assign r0_result = result_q;
    assign r1_result = result_q;
    assign busy      = (state_q != ST_IDLE);
    assign op_count  = count_q;

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one 32-bit logic unit (AND/OR/XOR/NOR, 2-bit op select: 00 AND, 01 OR, 10 XOR, 11 NOR) between two requesters, e.g. the main pipeline and a multi-cycle helper.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Grant is round-robin; operands, op and result are registered.
- Only one transaction is in flight at a time.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- r0_valid  input  1  requester 0 request valid.
- r0_ready  output  1  requester 0 request accepted this cycle.
- r0_op  input  2  requester 0 op select (00 AND, 01 OR, 10 XOR, 11 NOR).
- r0_a  input  WIDTH  requester 0 operand a.
- r0_b  input  WIDTH  requester 0 operand b.
- r0_rvalid  output  1  requester 0 result valid.
- r0_rready  input  1  requester 0 accepts result.
- r0_result  output  WIDTH  requester 0 result.
- r1_valid, r1_ready, r1_op, r1_a, r1_b, r1_rvalid, r1_rready, r1_result: same as requester 0, for requester 1.
- busy  output  1  high in any state other than IDLE.
- op_count  output  CNT_W  completed transactions, saturating.

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous and active-high.
- Reset values: state=IDLE, last_grant=1 (so requester 0 wins the first tie), op/a/b registers=0, result register=0, op_count=0, all rvalid=0, busy=0.
- State IDLE:
  - Grant selection: if exactly one rN_valid is high, that requester is granted. If both are high, grant the requester that is not last_grant.
  - rN_ready is combinational: (state==IDLE) && granted==N. At most one ready is high per cycle.
  - Handshake (valid && ready): latch op, a, b and owner; go to EXEC.
  - If no valid is high, stay in IDLE.
- State EXEC (1 cycle):
  - result_reg <= f(op, a, b) with f = a&b, a|b, a^b, ~(a|b).
  - Go to RESP.
- State RESP:
  - r<owner>_rvalid=1 and r<owner>_result=result_reg; the non-owner's rvalid=0.
  - Both ready outputs stay low.
  - On r<owner>_rready=1: go to IDLE, last_grant<=owner, and op_count<=op_count+1 unless it equals all-ones.
  - Otherwise hold; result and rvalid stay stable.
- Result port outside RESP: both rN_result ports drive result_reg at all times; rN_rvalid qualifies them.
- Latency: request handshake in cycle T; rvalid high from T+2.
- Minimum period: 3 cycles per transaction when rready is tied high.
- Fairness: under continuous requests from both, grants strictly alternate (0,1,0,1...).
- Single requester: a single requester is never blocked by the other's idle state.
- Requester inputs after acceptance: changing rN_op/a/b while a transaction is in flight has no effect on it.
- A non-granted requester's valid must be held by the requester; the arbiter never drops a request that was not handshaken.
- rready asserted outside RESP, or by the non-owner, is ignored.
- rst mid-transaction: the transaction is discarded; no rvalid pulse; counter clears to 0.
- Wrap/saturation: op_count holds at 2^CNT_W-1 and does not wrap.
- Invalid op: not possible, since all four op codes are defined.

Decomposition:
- Shared package holds:
  - op codes OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOR=2'b11;
  - FSM state encoding IDLE/EXEC/RESP;
  - requester id constants.
- One sub-module, logic_rr_arbiter: a combinational 2-way round-robin pick from (valid0, valid1, last_grant) -> (grant_valid, grant_id).
- The logic function is computed in-block from the package op codes.

Test Plan:
- r0 only, op=00, a=0xF0F0F0F0, b=0x0FF00FF0, rready=1 -> r0_ready in cycle T, r0_rvalid at T+2 with r0_result=0x00F000F0; r1_rvalid stays 0; op_count=1.
- r1 only, ops 01/10/11 back-to-back with the same operands -> results 0xFFF0FFF0, 0xFF00FF00, 0x000F000F; 3-cycle spacing; op_count=3.
- Both valid continuously from reset, 4 transactions each -> grant order 0,1,0,1,...; each result returns only on its owner port.
- r0 in RESP with rready=0 for 5 cycles, r1_valid high throughout -> r0_rvalid and r0_result stable, r1_ready stays 0; r1 is granted the cycle after r0_rready rises.
- Assert rst asynchronously during EXEC -> no rvalid; busy=0 and op_count=0 immediately; next request behaves as from reset (r0 wins the tie).
- Preload op_count to 0xFFFE, complete 3 transactions -> op_count ends at 0xFFFF.
